// File: rtl/pb_conf_sched.sv
// pb_conf_sched: round-robin scheduler that shares one packet-builder
// configuration port among NUM_REQ requesters. A granted descriptor is latched
// onto the pb_* outputs, the builder is started, and completion (or a timeout
// abort) is reported back to the granted requester as a one-cycle pulse.
module pb_conf_sched #(
   parameter int NUM_REQ = 2,
   parameter int DESC_W  = 95,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DESC_W-1:0] req_desc,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      req_err,
   output logic                      busy,
   output logic                      pb_start,
   input  logic                      pb_irq,
   output logic [31:0]               pb_addr_in,
   output logic [3:0]                pb_byte_cnt,
   output logic [3:0]                pb_pkt_type,
   output logic                      pb_ecc_en,
   output logic                      pb_crc_en,
   output logic                      pb_ins_ecc_err,
   output logic                      pb_ins_crc_err,
   output logic [3:0]                pb_ecc_val,
   output logic [7:0]                pb_crc_val,
   output logic [2:0]                pb_sop_val,
   output logic [3:0]                pb_data_sel,
   output logic [31:0]               pb_addr_out
);

   // Index width for requester numbers; a single requester still needs one bit.
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Counter wide enough to hold TIMEOUT without wrapping.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
   localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_gnt;
   logic [CNT_W-1:0]   r_cnt;
   logic [DESC_W-1:0]  r_desc;
   logic               r_start;
   logic [NUM_REQ-1:0] r_done;
   logic               r_err;
   logic               r_busy;

   logic [DESC_W-1:0]  w_desc [NUM_REQ];
   logic [IDX_W-1:0]   w_gnt_idx;
   logic               w_found;
   logic               w_accept;
   logic               w_timeout;
   logic [NUM_REQ-1:0] w_gnt_onehot;

   // Unpack the flat descriptor bus and build per-requester one-hot decodes.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign w_desc[gi]       = req_desc[gi*DESC_W +: DESC_W];
         assign req_ready[gi]    = w_accept && (w_gnt_idx == IDX_W'(gi));
         assign w_gnt_onehot[gi] = (r_gnt == IDX_W'(gi));
      end
   endgenerate

   // Round-robin search: first valid requester at or above the pointer, with wrap.
   always_comb begin
      logic [IDX_W:0] v_sum;
      logic [IDX_W-1:0] v_idx;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (v_sum >= (IDX_W+1)'(NUM_REQ)) begin
            v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
         end
         v_idx = v_sum[IDX_W-1:0];
         if (!w_found && req_valid[v_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = v_idx;
         end
      end
   end

   // Acceptance only happens in IDLE; held off while reset is asserted so a
   // requester never sees a handshake that the state machine then discards.
   assign w_accept  = (r_state == ST_IDLE) && !reset && w_found;
   assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

   // Main scheduler FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_gnt    <= '0;
         r_cnt    <= '0;
         r_desc   <= '0;
         r_start  <= 1'b0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= '0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_desc  <= w_desc[w_gnt_idx];
                  r_gnt   <= w_gnt_idx;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               // pb_irq is deliberately ignored here: a stale irq from the
               // previous job must not complete this one.
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (pb_irq) begin
                  // irq wins over a coincident timeout.
                  r_done  <= w_gnt_onehot;
                  r_err   <= 1'b0;
                  r_state <= ST_DONE;
               end else if (w_timeout) begin
                  r_done  <= w_gnt_onehot;
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (r_cnt != '1) begin
                  // Saturate so the counter never wraps when timeouts are off.
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               r_rr_ptr <= (r_gnt == IDX_LAST) ? '0 : r_gnt + IDX_W'(1);
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pb_start = r_start;
   assign req_done = r_done;
   assign req_err  = r_err;
   assign busy     = r_busy;

   // Fixed descriptor layout fanned out to the builder's config fields.
   assign pb_addr_in     = r_desc[31:0];
   assign pb_byte_cnt    = r_desc[35:32];
   assign pb_pkt_type    = r_desc[39:36];
   assign pb_ecc_en      = r_desc[40];
   assign pb_crc_en      = r_desc[41];
   assign pb_ins_ecc_err = r_desc[42];
   assign pb_ins_crc_err = r_desc[43];
   assign pb_ecc_val     = r_desc[47:44];
   assign pb_crc_val     = r_desc[55:48];
   assign pb_sop_val     = r_desc[58:56];
   assign pb_data_sel    = r_desc[62:59];
   assign pb_addr_out    = r_desc[94:63];

endmodule

// File: tb/tb_pb_conf_sched.sv
// Directed testbench for pb_conf_sched (2 requesters, TIMEOUT = 16).
module tb_pb_conf_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [189:0] req_desc;
   logic [1:0]   req_done;
   logic         req_err;
   logic         busy;
   logic         pb_start;
   logic         pb_irq;
   logic [31:0]  pb_addr_in;
   logic [3:0]   pb_byte_cnt;
   logic [3:0]   pb_pkt_type;
   logic         pb_ecc_en;
   logic         pb_crc_en;
   logic         pb_ins_ecc_err;
   logic         pb_ins_crc_err;
   logic [3:0]   pb_ecc_val;
   logic [7:0]   pb_crc_val;
   logic [2:0]   pb_sop_val;
   logic [3:0]   pb_data_sel;
   logic [31:0]  pb_addr_out;

   int n_checks = 0;
   int n_fail   = 0;

   pb_conf_sched #(.NUM_REQ(2), .DESC_W(95), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc),
      .req_done(req_done), .req_err(req_err), .busy(busy),
      .pb_start(pb_start), .pb_irq(pb_irq),
      .pb_addr_in(pb_addr_in), .pb_byte_cnt(pb_byte_cnt), .pb_pkt_type(pb_pkt_type),
      .pb_ecc_en(pb_ecc_en), .pb_crc_en(pb_crc_en),
      .pb_ins_ecc_err(pb_ins_ecc_err), .pb_ins_crc_err(pb_ins_crc_err),
      .pb_ecc_val(pb_ecc_val), .pb_crc_val(pb_crc_val), .pb_sop_val(pb_sop_val),
      .pb_data_sel(pb_data_sel), .pb_addr_out(pb_addr_out)
   );

   always #5 clk = ~clk;

   // Descriptor packing in layout order, LSB field last.
   function automatic logic [94:0] mk_desc(
      input logic [31:0] addr_in, input logic [3:0] byte_cnt, input logic [3:0] pkt_type,
      input logic ecc_en, input logic crc_en, input logic ins_ecc, input logic ins_crc,
      input logic [3:0] ecc_val, input logic [7:0] crc_val, input logic [2:0] sop,
      input logic [3:0] data_sel, input logic [31:0] addr_out);
      return {addr_out, data_sel, sop, crc_val, ecc_val, ins_crc, ins_ecc,
              crc_en, ecc_en, pkt_type, byte_cnt, addr_in};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 2'b00; req_desc = '0; pb_irq = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({busy, pb_start, req_done, req_err, req_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b start=%b done=%b err=%b ready=%b expected all 0",
                  busy, pb_start, req_done, req_err, req_ready);
      end
      n_checks++;
      if ({pb_addr_in, pb_addr_out, pb_crc_val} !== 72'd0) begin
         n_fail++;
         $display("FAIL reset_fields: got addr_in=%h addr_out=%h crc=%h expected 0",
                  pb_addr_in, pb_addr_out, pb_crc_val);
      end
      reset = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_single();
      req_desc[94:0] = mk_desc(32'h100, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0,
                               4'd0, 8'hA5, 3'd0, 4'd0, 32'h200);
      req_valid = 2'b01;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready);
      end
      tick();                              // cycle 1
      req_valid = 2'b00;
      n_checks++;
      if (pb_start !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", pb_start, busy);
      end
      n_checks++;
      if (pb_addr_in !== 32'h100 || pb_byte_cnt !== 4'd7 || pb_pkt_type !== 4'd2 ||
          pb_crc_en !== 1'b1 || pb_ecc_en !== 1'b0 || pb_crc_val !== 8'hA5 ||
          pb_addr_out !== 32'h200 || pb_sop_val !== 3'd0 || pb_data_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL single_fields: got addr_in=%h bc=%h pt=%h crc_en=%b crc=%h addr_out=%h expected 100 7 2 1 a5 200",
                  pb_addr_in, pb_byte_cnt, pb_pkt_type, pb_crc_en, pb_crc_val, pb_addr_out);
      end
      for (int k = 2; k <= 5; k++) begin
         tick();
         n_checks++;
         if (pb_start !== 1'b0 || req_done !== 2'b00) begin
            n_fail++; $display("FAIL single_wait c%0d: got start=%b done=%b expected 0 00", k, pb_start, req_done);
         end
      end
      tick();                              // cycle 6
      pb_irq = 1'b1;
      tick();                              // cycle 7
      pb_irq = 1'b0;
      n_checks++;
      if (req_done !== 2'b01 || req_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_done: got done=%b err=%b busy=%b expected 01 0 1", req_done, req_err, busy);
      end
      tick();                              // cycle 8
      n_checks++;
      if (req_done !== 2'b00 || busy !== 1'b0 || pb_addr_in !== 32'h100) begin
         n_fail++; $display("FAIL single_after: got done=%b busy=%b addr_in=%h expected 00 0 100", req_done, busy, pb_addr_in);
      end
      $display("single: job complete");
   endtask

   task automatic test_fairness();
      logic [1:0] exp_order [4];
      int gcyc [4];
      int ngr, ndone;
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
      ngr = 0; ndone = 0;
      reset = 1'b1; tick(); reset = 1'b0; tick();
      req_valid = 2'b11; pb_irq = 1'b1;
      for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
         #1;
         n_checks++;
         if ($countones(req_ready) > 1) begin
            n_fail++; $display("FAIL fair_onehot c%0d: got ready=%b expected at most one bit", cyc, req_ready);
         end
         if (req_ready !== 2'b00 && ngr < 4) begin
            n_checks++;
            if (req_ready !== exp_order[ngr]) begin
               n_fail++; $display("FAIL fair_grant%0d: got %b expected %b", ngr, req_ready, exp_order[ngr]);
            end
            $display("fairness: grant %0d ready=%b at cycle %0d", ngr, req_ready, cyc);
            gcyc[ngr] = cyc;
            ngr++;
         end
         if (req_done !== 2'b00 && ndone < ngr) begin
            n_checks++;
            if (req_done !== exp_order[ndone] || req_err !== 1'b0 || cyc != gcyc[ndone] + 3) begin
               n_fail++;
               $display("FAIL fair_done%0d: got done=%b err=%b latency=%0d expected %b 0 3",
                        ndone, req_done, req_err, cyc - gcyc[ndone], exp_order[ndone]);
            end
            ndone++;
         end
         @(posedge clk); #2;
         if (ngr == 4) req_valid = 2'b00;
      end
      n_checks++;
      if (ndone != 4) begin
         n_fail++; $display("FAIL fair_count: got %0d completions expected 4", ndone);
      end
      pb_irq = 1'b0; req_valid = 2'b00;
      tick();
   endtask

   task automatic test_timeout();
      req_desc[94:0] = mk_desc(32'hDEADBEEF, 4'd3, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1,
                               4'd9, 8'h3C, 3'd5, 4'hA, 32'h12345678);
      req_valid = 2'b01;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL to_ready: got %b expected 01", req_ready);
      end
      tick();                              // cycle 1
      req_valid = 2'b00;
      n_checks++;
      if (pb_start !== 1'b1 || pb_ecc_en !== 1'b1 || pb_ins_crc_err !== 1'b1 ||
          pb_ins_ecc_err !== 1'b0 || pb_ecc_val !== 4'd9 || pb_pkt_type !== 4'hC ||
          pb_byte_cnt !== 4'd3 || pb_crc_val !== 8'h3C) begin
         n_fail++;
         $display("FAIL to_fields: got start=%b ecc_en=%b ins_crc=%b ins_ecc=%b ecc=%h pt=%h bc=%h crc=%h expected 1 1 1 0 9 c 3 3c",
                  pb_start, pb_ecc_en, pb_ins_crc_err, pb_ins_ecc_err, pb_ecc_val, pb_pkt_type, pb_byte_cnt, pb_crc_val);
      end
      for (int k = 2; k <= 17; k++) begin
         tick();
         if (k == 5) req_desc[94:0] = '1;   // late descriptor change must not leak through
         n_checks++;
         if (req_done !== 2'b00 || busy !== 1'b1) begin
            n_fail++; $display("FAIL to_wait c%0d: got done=%b busy=%b expected 00 1", k, req_done, busy);
         end
         n_checks++;
         if (pb_addr_in !== 32'hDEADBEEF || pb_addr_out !== 32'h12345678 ||
             pb_sop_val !== 3'd5 || pb_data_sel !== 4'hA) begin
            n_fail++;
            $display("FAIL to_stable c%0d: got addr_in=%h addr_out=%h sop=%h sel=%h expected deadbeef 12345678 5 a",
                     k, pb_addr_in, pb_addr_out, pb_sop_val, pb_data_sel);
         end
      end
      tick();                              // cycle 18
      n_checks++;
      if (req_done !== 2'b01 || req_err !== 1'b1) begin
         n_fail++; $display("FAIL to_done: got done=%b err=%b expected 01 1", req_done, req_err);
      end
      tick();                              // cycle 19
      n_checks++;
      if (req_done !== 2'b00 || req_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL to_after: got done=%b err=%b busy=%b expected 00 0 0", req_done, req_err, busy);
      end
      $display("timeout: job aborted with error");
   endtask

   task automatic test_boundary();
      // irq on the last timeout cycle: pointer is now 1.
      req_desc[189:95] = mk_desc(32'h55, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 4'd0, 8'h00, 3'd1, 4'd1, 32'h66);
      req_valid = 2'b10;
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++; $display("FAIL bnd_ready: got %b expected 10", req_ready);
      end
      tick();                              // cycle 1
      req_valid = 2'b00;
      for (int k = 2; k <= 16; k++) tick();
      tick();                              // cycle 17: counter at TIMEOUT-1
      pb_irq = 1'b1;
      n_checks++;
      if (req_done !== 2'b00) begin
         n_fail++; $display("FAIL bnd_early: got done=%b expected 00", req_done);
      end
      tick();                              // cycle 18
      pb_irq = 1'b0;
      n_checks++;
      if (req_done !== 2'b10 || req_err !== 1'b0) begin
         n_fail++; $display("FAIL bnd_irq_wins: got done=%b err=%b expected 10 0", req_done, req_err);
      end
      tick();
      // irq held high from pb_start onward: ignored in START, done in cycle 3.
      req_valid = 2'b01;
      tick();                              // cycle 1
      req_valid = 2'b00;
      pb_irq = 1'b1;
      tick();                              // cycle 2
      n_checks++;
      if (req_done !== 2'b00) begin
         n_fail++; $display("FAIL bnd_start_ignore: got done=%b expected 00", req_done);
      end
      tick();                              // cycle 3
      pb_irq = 1'b0;
      n_checks++;
      if (req_done !== 2'b01 || req_err !== 1'b0) begin
         n_fail++; $display("FAIL bnd_first_wait: got done=%b err=%b expected 01 0", req_done, req_err);
      end
      tick();
      $display("boundary: irq-vs-timeout and early irq handled");
   endtask

   task automatic test_withdrawal();
      req_desc[94:0] = mk_desc(32'h100, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0,
                               4'd0, 8'hA5, 3'd0, 4'd0, 32'h200);
      req_valid = 2'b01;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL wd_ready: got %b expected 01", req_ready);
      end
      tick();                              // cycle 1
      req_valid = 2'b10;
      req_desc[94:0] = mk_desc(32'hFFFF0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                               4'd0, 8'h00, 3'd0, 4'd0, 32'h0);
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL wd_busy_ready: got %b expected 00", req_ready);
      end
      tick();                              // cycle 2
      req_valid = 2'b00;
      n_checks++;
      if (pb_addr_in !== 32'h100 || pb_addr_out !== 32'h200) begin
         n_fail++; $display("FAIL wd_stable: got addr_in=%h addr_out=%h expected 100 200", pb_addr_in, pb_addr_out);
      end
      tick();                              // cycle 3
      pb_irq = 1'b1;
      tick();                              // cycle 4
      pb_irq = 1'b0;
      n_checks++;
      if (req_done !== 2'b01) begin
         n_fail++; $display("FAIL wd_done: got %b expected 01", req_done);
      end
      for (int k = 5; k <= 9; k++) begin
         tick();
         n_checks++;
         if (busy !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL wd_never c%0d: got busy=%b ready=%b expected 0 00", k, busy, req_ready);
         end
      end
      $display("withdrawal: dropped request never granted");
   endtask

   task automatic test_reset_mid();
      // Pointer is 1 here; requester 1 is granted, then reset mid-wait.
      req_valid = 2'b10;
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++; $display("FAIL rm_ready: got %b expected 10", req_ready);
      end
      tick();                              // cycle 1
      req_valid = 2'b00;
      tick();                              // cycle 2
      tick();                              // cycle 3 (WAIT_IRQ)
      reset = 1'b1;
      tick();
      n_checks++;
      if ({busy, pb_start, req_done, req_err, req_ready} !== 6'b0 ||
          pb_addr_in !== 32'd0 || pb_addr_out !== 32'd0) begin
         n_fail++;
         $display("FAIL rm_clear: got busy=%b start=%b done=%b err=%b ready=%b addr_in=%h expected all 0",
                  busy, pb_start, req_done, req_err, req_ready, pb_addr_in);
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (req_done !== 2'b00 || req_err !== 1'b0) begin
            n_fail++; $display("FAIL rm_no_done c%0d: got done=%b err=%b expected 00 0", k, req_done, req_err);
         end
      end
      req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL rm_ptr: got ready=%b expected 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      $display("reset_mid: job dropped, pointer restarted at 0");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_boundary();
      test_withdrawal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
